// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the timekeeper: FSM states, digit_sel codes
// and the per-position clamp limits used while entering a time.
package timekeeper_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HT = 3'd1,
        SET_HO = 3'd2,
        SET_MT = 3'd3,
        SET_MO = 3'd4,
        COMMIT = 3'd5
    } state_t;

    localparam logic [2:0] SEL_HT     = 3'd0;
    localparam logic [2:0] SEL_HO     = 3'd1;
    localparam logic [2:0] SEL_MT     = 3'd2;
    localparam logic [2:0] SEL_MO     = 3'd3;
    localparam logic [2:0] SEL_COMMIT = 3'd4;
    localparam logic [2:0] SEL_RUN    = 3'd7;

    localparam logic [3:0] HT_MAX_24     = 4'd2;
    localparam logic [3:0] HT_MAX_12     = 4'd1;
    localparam logic [3:0] HO_MAX_24_HT2 = 4'd3;
    localparam logic [3:0] HO_MAX_12_HT1 = 4'd2;
    localparam logic [3:0] HO_MAX        = 4'd9;
    localparam logic [3:0] MT_MAX        = 4'd5;
    localparam logic [3:0] MO_MAX        = 4'd9;

    // Every limit is <= 9, so non-BCD inputs collapse onto the limit too.
    function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while running, strobes on the
// wrap (sec_pulse) and at the half-second point (half_tick).
module tick_divider #(
    parameter int TICKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic sec_pulse,
    output logic half_tick
);

    localparam int CW = $clog2(TICKS_PER_SEC);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] HALF = CW'(TICKS_PER_SEC / 2 - 1);

    logic [CW-1:0] count;

    // clr zeroes the count on the edge that leaves RUN so setup sees 0 at once.
    always_ff @(posedge clk) begin
        if (rst || !run || clr)  count <= '0;
        else if (count == LAST)  count <= '0;
        else                     count <= count + CW'(1);
    end

    assign sec_pulse = run && (count == LAST);
    assign half_tick = run && (count == HALF);

endmodule

// File: rtl/timekeeper_core.sv
// Digital clock core: BCD time of day with a digit-by-digit setup FSM,
// 12/24-hour modes and a display blink.
module timekeeper_core
    import timekeeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter bit MODE_12H      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic [3:0] digit_val,
    input  logic       digit_load,
    output logic       setup_mode,
    output logic [2:0] digit_sel,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       sec_pulse,
    output logic       blink
);

    localparam logic [3:0] RST_HT = MODE_12H ? 4'd1 : 4'd0;
    localparam logic [3:0] RST_HO = MODE_12H ? 4'd2 : 4'd0;
    localparam int BW = $clog2(TICKS_PER_SEC);
    localparam logic [BW-1:0] FREE_LAST = BW'(TICKS_PER_SEC / 2 - 1);

    state_t     state, state_next;
    logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o;
    logic [3:0] t_ht, t_ho, t_mt, t_mo;
    logic [3:0] nh_t, nh_o, ho_max, ho_val;
    logic       pm_q, pm_flip, half_tick, running, blink_q, free_wrap;
    logic [BW-1:0] free_cnt;

    assign running = (state == RUN);

    tick_divider #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_div (
        .clk      (clk),
        .rst      (rst),
        .run      (running),
        .clr      (running && set_req),
        .sec_pulse(sec_pulse),
        .half_tick(half_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= SET_HT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        setup_mode = 1'b1;
        digit_sel  = SEL_RUN;
        case (state)
            RUN: begin
                setup_mode = 1'b0;
                if (set_req) state_next = SET_HT;
            end
            SET_HT: begin
                digit_sel = SEL_HT;
                if (digit_load) state_next = SET_HO;
            end
            SET_HO: begin
                digit_sel = SEL_HO;
                if (digit_load) state_next = SET_MT;
            end
            SET_MT: begin
                digit_sel = SEL_MT;
                if (digit_load) state_next = SET_MO;
            end
            SET_MO: begin
                digit_sel = SEL_MO;
                if (digit_load) state_next = COMMIT;
            end
            COMMIT: begin
                digit_sel  = SEL_COMMIT;
                state_next = RUN;
            end
            default: state_next = SET_HT;
        endcase
    end

    // The hour-ones limit depends on the tens digit already captured.
    always_comb begin
        ho_max = HO_MAX;
        if (!MODE_12H && t_ht == 4'd2) ho_max = HO_MAX_24_HT2;
        if (MODE_12H && t_ht == 4'd1)  ho_max = HO_MAX_12_HT1;
        ho_val = clamp_digit(digit_val, ho_max);
        if (MODE_12H && t_ht == 4'd0 && ho_val == 4'd0) ho_val = 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_ht <= RST_HT;
            t_ho <= RST_HO;
            t_mt <= 4'd0;
            t_mo <= 4'd0;
        end else if (digit_load) begin
            case (state)
                SET_HT: t_ht <= clamp_digit(digit_val, MODE_12H ? HT_MAX_12 : HT_MAX_24);
                SET_HO: t_ho <= ho_val;
                SET_MT: t_mt <= clamp_digit(digit_val, MT_MAX);
                SET_MO: t_mo <= clamp_digit(digit_val, MO_MAX);
                default: ;
            endcase
        end
    end

    always_comb begin
        nh_t    = h_t;
        nh_o    = h_o + 4'd1;
        pm_flip = 1'b0;
        if (h_o == 4'd9) begin
            nh_t = h_t + 4'd1;
            nh_o = 4'd0;
        end
        if (!MODE_12H && h_t == 4'd2 && h_o == 4'd3) begin
            nh_t = 4'd0;
            nh_o = 4'd0;
        end
        if (MODE_12H && h_t == 4'd1 && h_o == 4'd2) begin
            nh_t = 4'd0;
            nh_o = 4'd1;
        end
        if (MODE_12H && h_t == 4'd1 && h_o == 4'd1) pm_flip = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_t <= RST_HT; h_o <= RST_HO; m_t <= 4'd0; m_o <= 4'd0;
            s_t <= 4'd0;   s_o <= 4'd0;   pm_q <= 1'b0;
        end else if (state == COMMIT) begin
            h_t <= t_ht; h_o <= t_ho; m_t <= t_mt; m_o <= t_mo;
            s_t <= 4'd0; s_o <= 4'd0; pm_q <= 1'b0;
        end else if (sec_pulse) begin
            if (s_o != 4'd9) s_o <= s_o + 4'd1;
            else begin
                s_o <= 4'd0;
                if (s_t != 4'd5) s_t <= s_t + 4'd1;
                else begin
                    s_t <= 4'd0;
                    if (m_o != 4'd9) m_o <= m_o + 4'd1;
                    else begin
                        m_o <= 4'd0;
                        if (m_t != 4'd5) m_t <= m_t + 4'd1;
                        else begin
                            m_t <= 4'd0;
                            h_t <= nh_t;
                            h_o <= nh_o;
                            if (pm_flip) pm_q <= ~pm_q;
                        end
                    end
                end
            end
        end
    end

    // Setup blinks from its own counter since the prescaler is parked at 0.
    assign free_wrap = (free_cnt == FREE_LAST);

    always_ff @(posedge clk) begin
        if (rst)            free_cnt <= '0;
        else if (free_wrap) free_cnt <= '0;
        else                free_cnt <= free_cnt + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) blink_q <= 1'b0;
        else if (running ? (half_tick || sec_pulse) : free_wrap) blink_q <= ~blink_q;
    end

    assign hour_tens = setup_mode ? t_ht : h_t;
    assign hour_ones = setup_mode ? t_ho : h_o;
    assign min_tens  = setup_mode ? t_mt : m_t;
    assign min_ones  = setup_mode ? t_mo : m_o;
    assign sec_tens  = setup_mode ? 4'd0 : s_t;
    assign sec_ones  = setup_mode ? 4'd0 : s_o;
    assign pm        = pm_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench: a 24-hour and a 12-hour instance (10 ticks/s) driven from
// a setup-vector table plus hand-written rollover, hold, collision and reset sequences.
module tb_timekeeper_core;

    logic       clk = 1'b0;
    logic       rst_i [2];
    logic       setr  [2];
    logic       dload [2];
    logic [3:0] dval  [2];
    logic       smode [2];
    logic [2:0] dsel  [2];
    logic [3:0] ht [2], ho [2], mt [2], mo [2], st [2], so [2];
    logic       pm_o [2], sp [2], bl [2];

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    timekeeper_core #(.TICKS_PER_SEC(10), .MODE_12H(1'b0)) u24 (
        .clk(clk), .rst(rst_i[0]), .set_req(setr[0]), .digit_val(dval[0]),
        .digit_load(dload[0]), .setup_mode(smode[0]), .digit_sel(dsel[0]),
        .hour_tens(ht[0]), .hour_ones(ho[0]), .min_tens(mt[0]), .min_ones(mo[0]),
        .sec_tens(st[0]), .sec_ones(so[0]), .pm(pm_o[0]), .sec_pulse(sp[0]), .blink(bl[0])
    );

    timekeeper_core #(.TICKS_PER_SEC(10), .MODE_12H(1'b1)) u12 (
        .clk(clk), .rst(rst_i[1]), .set_req(setr[1]), .digit_val(dval[1]),
        .digit_load(dload[1]), .setup_mode(smode[1]), .digit_sel(dsel[1]),
        .hour_tens(ht[1]), .hour_ones(ho[1]), .min_tens(mt[1]), .min_ones(mo[1]),
        .sec_tens(st[1]), .sec_ones(so[1]), .pm(pm_o[1]), .sec_pulse(sp[1]), .blink(bl[1])
    );

    typedef struct {
        int          m;
        logic [15:0] din;
        logic [15:0] hm;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [15:0] hm_of(input int m);
        return {ht[m], ho[m], mt[m], mo[m]};
    endfunction

    function automatic logic [23:0] hms_of(input int m);
        return {ht[m], ho[m], mt[m], mo[m], st[m], so[m]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic load_digit(input int m, input logic [3:0] v);
        dval[m]  = v;
        dload[m] = 1'b1;
        step();
        dload[m] = 1'b0;
    endtask

    // Enter setup if running, load four digits, then pass COMMIT into RUN.
    task automatic set_time(input int m, input logic [15:0] d);
        if (!smode[m]) begin
            setr[m] = 1'b1;
            step();
            setr[m] = 1'b0;
        end
        load_digit(m, d[15:12]);
        load_digit(m, d[11:8]);
        load_digit(m, d[7:4]);
        load_digit(m, d[3:0]);
        step();
    endtask

    // Run n cycles, counting sec_pulses, blink edges and the first pulse offset.
    task automatic run_cycles(input int m, input int n, output int pulses,
                              output int toggles, output int first);
        logic prev;
        pulses  = 0;
        toggles = 0;
        first   = -1;
        prev    = bl[m];
        for (int i = 0; i < n; i++) begin
            if (sp[m]) begin
                if (first < 0) first = i;
                pulses++;
            end
            step();
            if (bl[m] !== prev) toggles++;
            prev = bl[m];
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np, nt, nf;
        tbl[0] = '{0, 16'h2799, 16'h2359};
        tbl[1] = '{0, 16'h196F, 16'h1959};
        tbl[2] = '{0, 16'h3F00, 16'h2300};
        tbl[3] = '{0, 16'h0CA4, 16'h0954};
        tbl[4] = '{0, 16'h2272, 16'h2252};
        tbl[5] = '{1, 16'h0030, 16'h0130};
        tbl[6] = '{1, 16'h3500, 16'h1200};
        tbl[7] = '{1, 16'h1159, 16'h1159};
        tbl[8] = '{1, 16'h0F00, 16'h0900};
        tbl[9] = '{1, 16'h1F00, 16'h1200};

        for (int m = 0; m < 2; m++) begin
            rst_i[m] = 1'b1; setr[m] = 1'b0; dload[m] = 1'b0; dval[m] = 4'd0;
        end
        step();
        step();
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;

        check("rst24_ctrl", {smode[0], dsel[0], pm_o[0], sp[0], bl[0]}, {1'b1, 3'd0, 3'b000});
        check("rst24_time", hms_of(0), 24'h000000);
        check("rst12_ctrl", {smode[1], dsel[1], pm_o[1], sp[1], bl[1]}, {1'b1, 3'd0, 3'b000});
        check("rst12_time", hms_of(1), 24'h120000);

        for (int i = 0; i < 10; i++) begin
            set_time(tbl[i].m, tbl[i].din);
            check($sformatf("vec%0d_hm", i), hm_of(tbl[i].m), tbl[i].hm);
            check($sformatf("vec%0d_run", i), {smode[tbl[i].m], dsel[tbl[i].m], st[tbl[i].m], so[tbl[i].m]},
                  {1'b0, 3'd7, 8'h00});
        end

        // 24h: 23:59 rolls to midnight after 60 s.
        set_time(0, 16'h2799);
        check("wrap24_start", hms_of(0), 24'h235900);
        run_cycles(0, 600, np, nt, nf);
        check("wrap24_time", hms_of(0), 24'h000000);
        check("wrap24_pulses", np, 60);
        check("commit_latency", nf, 9);
        check("run_blink_edges", nt, 120);
        check("wrap24_pm", pm_o[0], 1'b0);

        // Hold in setup at 00:00:07.
        run_cycles(0, 70, np, nt, nf);
        check("hold_pre", hms_of(0), 24'h000007);
        setr[0] = 1'b1;
        step();
        setr[0] = 1'b0;
        check("hold_view", {smode[0], dsel[0], hms_of(0)}, {1'b1, 3'd0, 24'h235900});
        run_cycles(0, 30, np, nt, nf);
        check("hold_no_pulse", np, 0);
        check("setup_blink_edges", nt, 6);
        check("hold_state", {smode[0], dsel[0]}, {1'b1, 3'd0});

        // set_req and digit_load together in RUN: set_req wins, temp HT untouched.
        set_time(0, 16'h0000);
        setr[0] = 1'b1; dload[0] = 1'b1; dval[0] = 4'd2;
        step();
        setr[0] = 1'b0; dload[0] = 1'b0;
        check("collide_state", {smode[0], dsel[0], ht[0]}, {1'b1, 3'd0, 4'd0});
        step();
        check("collide_hold", {smode[0], dsel[0], ht[0]}, {1'b1, 3'd0, 4'd0});

        // Reset in SET_MT.
        load_digit(0, 4'd1);
        load_digit(0, 4'd5);
        check("mid_setup", {dsel[0], hm_of(0)}, {3'd2, 16'h1500});
        rst_i[0] = 1'b1;
        step();
        rst_i[0] = 1'b0;
        check("rst_mid_state", {smode[0], dsel[0], pm_o[0], sp[0], bl[0]}, {1'b1, 3'd0, 3'b000});
        check("rst_mid_time", hms_of(0), 24'h000000);

        // 12h: 11:59 -> 12:00 pm, then 12:59 -> 01:00.
        set_time(1, 16'h1159);
        run_cycles(1, 600, np, nt, nf);
        check("roll12_noon", {pm_o[1], hms_of(1)}, {1'b1, 24'h120000});
        check("roll12_pulses", np, 60);
        set_time(1, 16'h1259);
        check("set1259_pm", {pm_o[1], hms_of(1)}, {1'b0, 24'h125900});
        run_cycles(1, 600, np, nt, nf);
        check("roll12_one", {pm_o[1], hms_of(1)}, {1'b0, 24'h010000});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
